deskew_buffer: RTL and testbench

//  Output-side counterpart of skew_buffer. The systolic array emits results diagonally:

---
 rtl/systolic_pkg.sv | 7 +
 rtl/delay_line.sv | 34 +++
 rtl/deskew_buffer.sv | 79 +++++++
 tb/tb_deskew_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Defaults shared by skew_buffer, the PE array and deskew_buffer.
package systolic_pkg;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int ARRAY_SIZE_DEF = 8;

  typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;
endpackage

// File: rtl/delay_line.sv
// DEPTH-stage shift register that advances only when enable is high; DEPTH=0 is a wire.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, enable};
      assign q = d;
    end else begin : g_sr
      logic [DEPTH-1:0][WIDTH-1:0] stage;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage <= '0;
        end else if (enable) begin
          stage[0] <= d;
          for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/deskew_buffer.sv
// Re-aligns the diagonally skewed result rows of the systolic array: lane i is
// delayed ARRAY_SIZE-1-i cycles so a complete row leaves on a single cycle.
module deskew_buffer
  import systolic_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  localparam int IW        = $clog2(ARRAY_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        valid_in,
  input  logic signed [ACC_WIDTH-1:0] data_in  [ARRAY_SIZE],
  output logic signed [ACC_WIDTH-1:0] data_out [ARRAY_SIZE],
  output logic                        valid_out,
  output logic [IW-1:0]               row_idx,
  output logic                        out_last
);

  localparam logic [IW-1:0] LAST = IW'(ARRAY_SIZE - 1);

  logic [ACC_WIDTH-1:0] lane_dly [ARRAY_SIZE];
  logic                 vld_tail;
  logic [IW-1:0]        row_next;

  generate
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      delay_line #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (ARRAY_SIZE - 1 - i)
      ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (data_in[i]),
        .q      (lane_dly[i])
      );
    end
  endgenerate

  // valid_in travels with lane 0, so it sees lane 0's delay depth
  delay_line #(
    .WIDTH (1),
    .DEPTH (ARRAY_SIZE - 1)
  ) u_vld (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (valid_in),
    .q      (vld_tail)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARRAY_SIZE; i++) data_out[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < ARRAY_SIZE; i++) data_out[i] <= lane_dly[i];
    end
  end

  // row_idx names the row currently shown; row_next is the index the next valid row takes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      row_idx   <= '0;
      row_next  <= '0;
    end else begin
      valid_out <= enable & vld_tail;
      if (enable && vld_tail) begin
        row_idx  <= row_next;
        row_next <= (row_next == LAST) ? '0 : row_next + 1'b1;
      end
    end
  end

  assign out_last = valid_out && (row_idx == LAST);

endmodule

// File: tb/tb_deskew_buffer.sv
// Directed + randomized bench for deskew_buffer against a row-history reference model.
module tb_deskew_buffer;
  localparam int N = 8;
  localparam int W = 32;

  typedef struct {
    logic signed [W-1:0] d [N];
    bit                  v;
  } rec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic                valid_in;
  logic signed [W-1:0] data_in  [N];
  logic signed [W-1:0] data_out [N];
  logic                valid_out;
  logic [2:0]          row_idx;
  logic                out_last;

  int vectors = 0;
  int miscompares = 0;

  rec_t                hist [$];
  logic signed [W-1:0] exp_d [N];
  bit                  exp_v;
  int                  emitted;
  int                  exp_idx;
  int                  vld_seen;
  int                  last_seen;

  deskew_buffer #(.ACC_WIDTH(W), .ARRAY_SIZE(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .row_idx   (row_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    hist = {};
    for (int i = 0; i < N; i++) exp_d[i] = '0;
    exp_v   = 1'b0;
    emitted = 0;
    exp_idx = 0;
  endtask

  // After an enabled edge, lane i shows the input captured N-1-i enabled edges earlier.
  task automatic model_edge();
    rec_t r;
    int   n;
    if (!rst) return;
    if (!enable) begin
      exp_v = 1'b0;
      return;
    end
    r.v = valid_in;
    for (int i = 0; i < N; i++) r.d[i] = data_in[i];
    hist.push_back(r);
    if (hist.size() > N) hist.delete(0);
    n = hist.size();
    for (int i = 0; i < N; i++) exp_d[i] = (n - N + i >= 0) ? hist[n-N+i].d[i] : '0;
    exp_v = (n == N) ? hist[0].v : 1'b0;
    if (exp_v) begin
      emitted++;
      exp_idx = (emitted - 1) % N;
    end
  endtask

  task automatic check_all();
    chk("valid_out", {63'd0, valid_out}, {63'd0, exp_v});
    chk("row_idx", {61'd0, row_idx}, 64'(exp_idx));
    chk("out_last", {63'd0, out_last}, {63'd0, (exp_v && exp_idx == N-1)});
    for (int i = 0; i < N; i++)
      chk($sformatf("data_out[%0d]", i), 64'(data_out[i]), 64'(exp_d[i]));
    if (valid_out) vld_seen++;
    if (out_last) last_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_random(input bit vin_rand);
    for (int i = 0; i < N; i++) data_in[i] = $urandom;
    valid_in = vin_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  function automatic logic signed [W-1:0] row_val(input int kind, input int k, input int i);
    if (kind == 0) return W'(100 * k + i);
    return ((k + i) % 2 == 1) ? -32'sd1 : 32'sh8000_0000;
  endfunction

  task automatic async_reset_pulse();
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_all();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Feeds nrows skewed rows; stream position only advances on enabled cycles.
  task automatic run_stream(input int nrows, input int kind, input int stall_lo,
                            input int stall_hi, input int rst_at);
    int s = 0;
    for (int c = 0; c < nrows + 2 * N + (stall_hi - stall_lo + 1); c++) begin
      if (c == rst_at) begin
        async_reset_pulse();
        valid_in = 1'b0;
        for (int t = 0; t < 2 * N; t++) begin
          drive_random(1'b0);
          tick();
        end
        return;
      end
      enable = !(c >= stall_lo && c <= stall_hi);
      if (enable) begin
        for (int i = 0; i < N; i++)
          data_in[i] = (s - i >= 0 && s - i < nrows) ? row_val(kind, s - i, i) : W'($urandom);
        valid_in = (s < nrows);
        s++;
      end else begin
        drive_random(1'b1);
      end
      tick();
    end
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < N; i++) data_in[i] = '0;
    model_clear();
    vld_seen = 0;
    last_seen = 0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;
    enable = 1'b1;

    // eight aligned rows
    vld_seen = 0; last_seen = 0;
    run_stream(8, 0, -1, -2, -1);
    chk("rows_plain", 64'(vld_seen), 64'd8);
    chk("last_plain", 64'(last_seen), 64'd1);

    // stall of three cycles mid-stream
    vld_seen = 0; last_seen = 0;
    run_stream(8, 0, 10, 12, -1);
    chk("rows_stall", 64'(vld_seen), 64'd8);
    chk("last_stall", 64'(last_seen), 64'd1);

    // async reset mid-stream: nothing of the partial rows may emerge
    vld_seen = 0;
    run_stream(8, 0, -1, -2, 5);
    chk("rows_after_rst", 64'(vld_seen), 64'd0);

    // extreme signed values
    vld_seen = 0;
    run_stream(8, 1, -1, -2, -1);
    chk("rows_signed", 64'(vld_seen), 64'd8);

    // 16 back-to-back rows
    vld_seen = 0; last_seen = 0;
    run_stream(16, 0, -1, -2, -1);
    chk("rows_b2b", 64'(vld_seen), 64'd16);
    chk("last_b2b", 64'(last_seen), 64'd2);

    // random enable / valid / data with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      drive_random(1'b1);
      if (c == 200) async_reset_pulse();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
